// File: rtl/key_kick_gen.sv
// key_kick_gen
//   Initiator side of the speaker watchdog link. Synchronizes and debounces a
//   raw key-valid level plus its 8-bit key code. On each accepted press, and
//   periodically while the key stays held, it emits a one-cycle kick. It also
//   keeps the accepted code on a stable data word.
//
// Ports
//   clk          system clock
//   RST          synchronous active-high reset
//   key_raw      asynchronous key-valid level from the keypad/scanner
//   key_code     asynchronous 8-bit code accompanying key_raw
//   kick         one-cycle pulse, drives the watchdog RST
//   data         last accepted key code, drives the watchdog Data
//   pressed      high while a debounced press is active
//   press_count  number of accepted presses (wraps at 16 bits)
module key_kick_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        key_raw,
  input  logic [7:0]  key_code,
  output logic        kick,
  output logic [7:0]  data,
  output logic        pressed,
  output logic [15:0] press_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit               REP_EN   = (REPEAT_CYCLES != 0);
  // REPEAT_CYCLES-1 would underflow when repeat is disabled, so clamp it.
  localparam logic [CNT_W-1:0] REP_LAST = REP_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  logic        key_m, key_s;
  logic [7:0]  code_m, code_s;

  state_t           state, state_n;
  logic [7:0]       cand, cand_n;
  logic [CNT_W-1:0] db_cnt, db_cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  logic             kick_n;
  logic [7:0]       data_n;
  logic             pressed_n;
  logic [15:0]      press_count_n;

  // Counters saturate instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizers. The code bus is sampled flop-by-flop like the
  // strobe; a code word caught mid-change is simply treated as an unstable
  // candidate by the debouncer, so no handshaking is needed.
  always_ff @(posedge clk) begin
    if (RST) begin
      key_m  <= 1'b0;
      key_s  <= 1'b0;
      code_m <= 8'h00;
      code_s <= 8'h00;
    end else begin
      key_m  <= key_raw;
      key_s  <= key_m;
      code_m <= key_code;
      code_s <= code_m;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      cand        <= 8'h00;
      db_cnt      <= '0;
      rep_cnt     <= '0;
      kick        <= 1'b0;
      data        <= 8'h00;
      pressed     <= 1'b0;
      press_count <= 16'h0000;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      db_cnt      <= db_cnt_n;
      rep_cnt     <= rep_cnt_n;
      kick        <= kick_n;
      data        <= data_n;
      pressed     <= pressed_n;
      press_count <= press_count_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    cand_n        = cand;
    db_cnt_n      = db_cnt;
    rep_cnt_n     = rep_cnt;
    kick_n        = 1'b0;
    data_n        = data;
    pressed_n     = pressed;
    press_count_n = press_count;

    unique case (state)
      IDLE: begin
        if (key_s) begin
          cand_n   = code_s;
          db_cnt_n = {{(CNT_W-1){1'b0}}, 1'b1};
          state_n  = PRESS_DB;
        end
      end

      PRESS_DB: begin
        if (!key_s) begin
          // An abandoned press, including a code change that never settled,
          // leaves no active press behind.
          pressed_n = 1'b0;
          state_n   = IDLE;
        end else if (code_s != cand) begin
          cand_n   = code_s;
          db_cnt_n = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (db_cnt == DB_LIMIT) begin
          kick_n        = 1'b1;
          data_n        = cand;
          pressed_n     = 1'b1;
          press_count_n = press_count + 16'd1;
          rep_cnt_n     = '0;
          state_n       = HELD;
        end else begin
          db_cnt_n = sat_inc(db_cnt);
        end
      end

      HELD: begin
        if (!key_s) begin
          db_cnt_n = {{(CNT_W-1){1'b0}}, 1'b1};
          state_n  = RELEASE_DB;
        end else if (code_s != data) begin
          cand_n   = code_s;
          db_cnt_n = {{(CNT_W-1){1'b0}}, 1'b1};
          state_n  = PRESS_DB;
        end else if (REP_EN && (rep_cnt == REP_LAST) && !kick) begin
          // The !kick guard keeps pulses apart even with a 1-cycle repeat.
          kick_n    = 1'b1;
          rep_cnt_n = '0;
        end else if (!(REP_EN && (rep_cnt == REP_LAST))) begin
          rep_cnt_n = sat_inc(rep_cnt);
        end
      end

      RELEASE_DB: begin
        if (key_s && (code_s == data)) begin
          rep_cnt_n = '0;
          state_n   = HELD;
        end else if (key_s) begin
          cand_n   = code_s;
          db_cnt_n = {{(CNT_W-1){1'b0}}, 1'b1};
          state_n  = PRESS_DB;
        end else if (db_cnt == DB_LIMIT) begin
          pressed_n = 1'b0;
          state_n   = IDLE;
        end else begin
          db_cnt_n = sat_inc(db_cnt);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_kick_gen.sv
// tb_key_kick_gen
//   Self-checking bench for key_kick_gen. A behavioural reference model works
//   on run lengths of synchronized samples (how long the key/code has been
//   steady) rather than on explicit debounce counters, and is compared against
//   the DUT every cycle under directed and random stimulus. A second instance
//   with a 1-cycle debounce exercises the 16-bit press counter wrap.
module tb_key_kick_gen;

  localparam int DB = 4;
  localparam int RP = 10;

  logic        clk = 1'b0;
  logic        rst, key_raw;
  logic [7:0]  key_code;
  logic        kick, pressed;
  logic [7:0]  data;
  logic [15:0] press_count;

  logic        w_rst, w_raw;
  logic [7:0]  w_code;
  logic        w_kick, w_pressed;
  logic [7:0]  w_data;
  logic [15:0] w_count;

  always #5 clk = ~clk;

  key_kick_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .CNT_W(32)) dut (
    .clk(clk), .RST(rst), .key_raw(key_raw), .key_code(key_code),
    .kick(kick), .data(data), .pressed(pressed), .press_count(press_count)
  );

  key_kick_gen #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(0), .CNT_W(8)) u_wrap (
    .clk(clk), .RST(w_rst), .key_raw(w_raw), .key_code(w_code),
    .kick(w_kick), .data(w_data), .pressed(w_pressed), .press_count(w_count)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int dut_kicks = 0;
  int last_kick_cyc = -1;
  logic prev_dut_kick = 1'b0;

  // Reference model state.
  int          m_mode;     // 0 idle, 1 press pending, 2 held, 3 release pending
  logic        m_kick;
  logic [7:0]  m_data;
  logic        m_pressed;
  logic [15:0] m_count;
  int          hi_run, lo_run, held_age;
  logic        prev_k;
  logic [7:0]  prev_c;
  logic [8:0]  sq[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_mode = 0; m_kick = 1'b0; m_data = 8'h00; m_pressed = 1'b0; m_count = 16'h0;
    hi_run = 0; lo_run = 0; held_age = 0; prev_k = 1'b0; prev_c = 8'h00;
    sq = '{9'h000, 9'h000};
  endtask

  // One clock edge of the reference: the sample the debouncer sees is the
  // input from two edges earlier; acceptance/release need a steady run of
  // DB+1 samples counted from the sample that started the run.
  task automatic modelStep(input logic r, input logic raw, input logic [7:0] code);
    logic [8:0] smp;
    logic       k, was_kick;
    logic [7:0] c;
    if (r) begin
      modelReset();
      return;
    end
    smp = sq.pop_front();
    sq.push_back({raw, code});
    k = smp[8];
    c = smp[7:0];
    if (k) begin
      hi_run = (prev_k && prev_c == c) ? hi_run + 1 : 1;
      lo_run = 0;
    end else begin
      lo_run = prev_k ? 1 : lo_run + 1;
      hi_run = 0;
    end
    prev_k = k;
    prev_c = c;
    was_kick = m_kick;
    m_kick = 1'b0;
    case (m_mode)
      0: if (k) m_mode = 1;
      1: begin
        if (!k) begin
          m_mode = 0; m_pressed = 1'b0;
        end else if (hi_run == DB + 1) begin
          m_kick = 1'b1; m_data = c; m_pressed = 1'b1; m_count = m_count + 16'd1;
          m_mode = 2; held_age = 0;
        end
      end
      2: begin
        if (!k) m_mode = 3;
        else if (c != m_data) m_mode = 1;
        else if (held_age == RP - 1 && !was_kick) begin
          m_kick = 1'b1; held_age = 0;
        end else held_age++;
      end
      default: begin
        if (k && c == m_data) begin
          m_mode = 2; held_age = 0;
        end else if (k) m_mode = 1;
        else if (lo_run == DB + 1) begin
          m_mode = 0; m_pressed = 1'b0;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic r, input logic raw, input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; key_raw = raw; key_code = code;
      @(posedge clk);
      cyc++;
      modelStep(r, raw, code);
      #1;
      checkOutput("kick", {31'd0, kick}, {31'd0, m_kick});
      checkOutput("data", {24'd0, data}, {24'd0, m_data});
      checkOutput("pressed", {31'd0, pressed}, {31'd0, m_pressed});
      checkOutput("press_count", {16'd0, press_count}, {16'd0, m_count});
      checkOutput("double_kick", {31'd0, kick & prev_dut_kick}, 32'd0);
      prev_dut_kick = kick;
      if (kick) begin
        dut_kicks++;
        last_kick_cyc = cyc;
      end
    end
  endtask

  task automatic wrapDrive(input logic r, input logic raw, input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w_rst = r; w_raw = raw; w_code = code;
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    int base, start;
    logic [7:0] codes [3];
    codes[0] = 8'h20; codes[1] = 8'h21; codes[2] = 8'h22;
    rst = 1'b1; key_raw = 1'b0; key_code = 8'h00;
    w_rst = 1'b1; w_raw = 1'b0; w_code = 8'h00;
    modelReset();

    // Reset held with the key active: outputs stay cleared.
    applyStimulus(1'b1, 1'b1, 8'h3C, 3);
    applyStimulus(1'b0, 1'b0, 8'h00, 5);

    // Clean press: one kick, DB+2 edges after the key first appears.
    base = dut_kicks;
    start = cyc + 1;
    applyStimulus(1'b0, 1'b1, 8'h3C, 8);
    checkOutput("clean_latency", last_kick_cyc - start, DB + 2);
    applyStimulus(1'b0, 1'b0, 8'h3C, 12);
    checkOutput("clean_kicks", dut_kicks - base, 1);
    checkOutput("clean_data", {24'd0, data}, 32'h3C);
    checkOutput("clean_released", {31'd0, pressed}, 32'd0);

    // Bounce on press, then a stable 0x41 press.
    base = dut_kicks;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, ~i[0], 8'h41, 1);
    applyStimulus(1'b0, 1'b0, 8'h41, 0);
    checkOutput("bounce_kicks", dut_kicks - base, 0);
    base = dut_kicks;
    applyStimulus(1'b0, 1'b1, 8'h41, 10);
    checkOutput("bounce_accept_kicks", dut_kicks - base, 1);
    checkOutput("bounce_data", {24'd0, data}, 32'h41);
    applyStimulus(1'b0, 1'b0, 8'h41, 12);

    // Held key: acceptance kick plus repeats every RP cycles.
    base = dut_kicks;
    applyStimulus(1'b0, 1'b1, 8'h45, 46);
    checkOutput("repeat_kicks", dut_kicks - base, 4);

    // Short release bounce, then a code change counts as a new press.
    applyStimulus(1'b0, 1'b0, 8'h45, 2);
    applyStimulus(1'b0, 1'b1, 8'h45, 5);
    checkOutput("rel_bounce_pressed", {31'd0, pressed}, 32'd1);
    base = dut_kicks;
    applyStimulus(1'b0, 1'b1, 8'h48, 8);
    checkOutput("change_kicks", dut_kicks - base, 1);
    checkOutput("change_data", {24'd0, data}, 32'h48);
    checkOutput("change_count", {16'd0, press_count}, 32'd4);
    applyStimulus(1'b0, 1'b0, 8'h48, 12);

    // Reset in the middle of press debounce.
    applyStimulus(1'b0, 1'b1, 8'h50, 5);
    applyStimulus(1'b1, 1'b1, 8'h50, 1);
    checkOutput("midrst_kick", {31'd0, kick}, 32'd0);
    checkOutput("midrst_count", {16'd0, press_count}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 10);

    // Random segments against the reference model.
    for (int s = 0; s < 300; s++) begin
      logic r, raw;
      int len;
      r   = ($urandom_range(0, 59) == 0);
      raw = $urandom_range(0, 3) != 0;
      len = r ? 1 : (($urandom_range(0, 4) == 0) ? $urandom_range(15, 35) : $urandom_range(1, 8));
      applyStimulus(r, raw, codes[$urandom_range(0, 2)], len);
    end

    // Counter wrap on the fast-debounce instance, preloaded near the top.
    wrapDrive(1'b1, 1'b0, 8'h00, 2);
    wrapDrive(1'b0, 1'b0, 8'h00, 2);
    @(negedge clk);
    force u_wrap.press_count = 16'hFFFD;
    #1;
    release u_wrap.press_count;
    wrapDrive(1'b0, 1'b1, 8'h01, 6);
    checkOutput("wrap_fffe", {16'd0, w_count}, 32'h0000FFFE);
    wrapDrive(1'b0, 1'b1, 8'h02, 6);
    checkOutput("wrap_ffff", {16'd0, w_count}, 32'h0000FFFF);
    wrapDrive(1'b0, 1'b1, 8'h01, 6);
    checkOutput("wrap_zero", {16'd0, w_count}, 32'h00000000);
    wrapDrive(1'b0, 1'b1, 8'h02, 6);
    checkOutput("wrap_one", {16'd0, w_count}, 32'h00000001);
    checkOutput("wrap_data", {24'd0, w_data}, 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
